// File: rtl/sprite_renderer_pkg.sv
// ----------------------------------------------------------------------------
// sprite_renderer_pkg
// Shared constants and state encoding for the sprite renderer.
//   LCD_WIDTH / LCD_HEIGHT : visible panel size used for clipping
//   TRANSPARENT_RGB        : colour key skipped when SPRITE_TRANSPARENCY_EN
//   state_t                : renderer FSM states
// ----------------------------------------------------------------------------
package sprite_renderer_pkg;

    localparam int          LCD_WIDTH       = 240;
    localparam int          LCD_HEIGHT      = 320;
    localparam logic [15:0] TRANSPARENT_RGB = 16'hF81F;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// ----------------------------------------------------------------------------
// sprite_addr_gen
// Row/column walker over one sprite and the matching sprite ROM address.
// Ports:
//   clock, reset      : system clock, async active-high reset
//   i_clear           : restart at row 0, col 0
//   i_advance         : step to the next pixel in raster order
//   i_sprite_id       : latched ROM slot (1024 words per slot)
//   o_col, o_row      : current pixel position inside the sprite
//   o_last            : current pixel is the bottom-right one
//   o_rom_addr        : sprite_id*1024 + row*SPRITE_W + col
// ----------------------------------------------------------------------------
module sprite_addr_gen
    import sprite_renderer_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int COL_W    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
    parameter int ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [3:0]       i_sprite_id,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last,
    output logic [13:0]      o_rom_addr
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_end;
    logic             w_row_end;

    assign w_col_end = (r_col == COL_W'(SPRITE_W - 1));
    assign w_row_end = (r_row == ROW_W'(SPRITE_H - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                // Explicit wrap keeps non-power-of-two heights in range.
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last     = w_col_end && w_row_end;
    assign o_rom_addr = (14'(i_sprite_id) << 10)
                      + (14'(r_row) * 14'(SPRITE_W))
                      + 14'(r_col);

endmodule

// File: rtl/sprite_renderer.sv
// ----------------------------------------------------------------------------
// sprite_renderer
// Copies one SPRITE_W x SPRITE_H sprite from ROM to the LCD write port,
// clipping pixels that fall outside the 240x320 panel.
// Build option:
//   SPRITE_TRANSPARENCY_EN : when defined, ROM words equal to TRANSPARENT_RGB
//                            are skipped like clipped pixels.
// Ports:
//   clock, reset                     : system clock, async active-high reset
//   start, x_sprite, y_sprite,
//   sprite_id                        : draw request and its placement/slot
//   rom_addr / rom_data              : sprite ROM, data one cycle after addr
//   pixel_x, pixel_y, pixel_rgb,
//   pixel_write / pixel_ready        : LCD pixel write handshake
//   busy                             : draw in progress
//   done                             : one-cycle completion pulse
// ----------------------------------------------------------------------------
module sprite_renderer
    import sprite_renderer_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x_sprite,
    input  logic [8:0]  y_sprite,
    input  logic [3:0]  sprite_id,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_rgb,
    output logic        pixel_write,
    input  logic        pixel_ready,
    output logic        busy,
    output logic        done
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    state_t           r_state;
    state_t           w_next_state;

    logic [7:0]       r_x;
    logic [8:0]       r_y;
    logic [3:0]       r_id;
    logic [7:0]       r_pixel_x;
    logic [8:0]       r_pixel_y;
    logic [15:0]      r_pixel_rgb;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last;
    logic [8:0]       w_sum_x;
    logic [9:0]       w_sum_y;
    logic             w_transparent;
    logic             w_skip;

    logic             w_load;
    logic             w_clear;
    logic             w_advance;
    logic             w_capture;
    logic             w_pixel_write;
    logic             w_busy;
    logic             w_done;

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_advance   (w_advance),
        .i_sprite_id (r_id),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_last      (w_last),
        .o_rom_addr  (rom_addr)
    );

    // One bit wider than the operands so a sprite hanging past the panel
    // edge cannot wrap back into the visible area.
    assign w_sum_x = {1'b0, r_x} + 9'(w_col);
    assign w_sum_y = {1'b0, r_y} + 10'(w_row);

`ifdef SPRITE_TRANSPARENCY_EN
    assign w_transparent = (rom_data == TRANSPARENT_RGB);
`else
    assign w_transparent = 1'b0;
`endif

    assign w_skip = (w_sum_x >= 9'(LCD_WIDTH))
                 || (w_sum_y >= 10'(LCD_HEIGHT))
                 || w_transparent;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        w_advance     = 1'b0;
        w_capture     = 1'b0;
        w_pixel_write = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_clear      = 1'b1;
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_busy       = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                // rom_data is valid here for the address presented in FETCH.
                w_busy = 1'b1;
                if (w_skip) begin
                    w_advance    = 1'b1;
                    w_next_state = w_last ? DONE : FETCH;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_busy        = 1'b1;
                w_pixel_write = 1'b1;
                if (pixel_ready) begin
                    w_advance    = 1'b1;
                    w_next_state = w_last ? DONE : FETCH;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_id        <= '0;
            r_pixel_x   <= '0;
            r_pixel_y   <= '0;
            r_pixel_rgb <= '0;
        end else begin
            if (w_load) begin
                r_x  <= x_sprite;
                r_y  <= y_sprite;
                r_id <= sprite_id;
            end
            // Only updated for pixels that will be written, so the LCD port
            // holds its values through any pixel_ready stall.
            if (w_capture) begin
                r_pixel_x   <= w_sum_x[7:0];
                r_pixel_y   <= w_sum_y[8:0];
                r_pixel_rgb <= rom_data;
            end
        end
    end

    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign pixel_rgb   = r_pixel_rgb;
    assign pixel_write = w_pixel_write;
    assign busy        = w_busy;
    assign done        = w_done;

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, meaning sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 32, meaning sprite height in pixels.
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to draw one sprite.
REQ-006 SHALL have port x_sprite  input  8  sprite top-left column (0..239).
REQ-007 SHALL have port y_sprite  input  9  sprite top-left row (0..319).
REQ-008 SHALL have port sprite_id  input  4  sprite ROM slot.
REQ-009 SHALL have port rom_addr  output  14  sprite ROM address.
REQ-010 SHALL have port rom_data  input  16  RGB565 ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have port pixel_x  output  8  LCD write column.
REQ-012 SHALL have port pixel_y  output  9  LCD write row.
REQ-013 SHALL have port pixel_rgb  output  16  LCD write colour.
REQ-014 SHALL have port pixel_write  output  1  pixel write request.
REQ-015 SHALL have port pixel_ready  input  1  LCD accepts the pixel in cycles where pixel_write and pixel_ready are both high.
REQ-016 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a sprite draw completes.

Function
REQ-018 SHALL use FSM states IDLE, FETCH, WAIT, WRITE, DONE.
REQ-019 IDLE: on start=1, SHALL latch x_sprite, y_sprite, sprite_id, clear row/col to 0, and go to FETCH.
REQ-020 Any start outside IDLE SHALL be ignored; it is not queued.
REQ-021 FETCH: SHALL drive rom_addr = sprite_id*1024 + row*SPRITE_W + col (14-bit, no overflow at defaults), then go to WAIT.
REQ-022 WAIT: SHALL register rom_data into pixel_rgb, set pixel_x = x+col and pixel_y = y+row, then go to WRITE.
REQ-023 WRITE: SHALL hold pixel_write high with stable pixel_x, pixel_y, pixel_rgb until pixel_ready=1; the handshake SHALL complete in that cycle.
REQ-024 Clipping: a pixel with x+col>=240 or y+row>=320 SHALL NOT be written; the block SHALL skip WRITE and advance directly. Sums SHALL be computed one bit wider than the operands.
REQ-025 Advance: col++; when col = SPRITE_W-1, col SHALL wrap to 0 and row++; after the pixel at row = SPRITE_H-1, col = SPRITE_W-1, the block SHALL go to DONE, otherwise to FETCH.
REQ-026 DONE: SHALL assert done for exactly one cycle, then go to IDLE; busy SHALL be low in DONE.
REQ-027 Throughput: with pixel_ready held at 1, SHALL take 3 cycles per written pixel.
REQ-028 pixel_write SHALL be high only in WRITE.

Reset
REQ-029 On reset=1, from any state including mid-sprite, the FSM SHALL enter IDLE immediately.
REQ-030 On reset=1, all outputs, counters, and latched registers SHALL be 0.
REQ-031 After reset is released, the block SHALL wait for a new start; the interrupted sprite SHALL NOT resume.

Configuration
REQ-032 When macro SPRITE_TRANSPARENCY_EN is defined, a pixel with rom_data = 16'hF81F SHALL be skipped like a clipped pixel, with no pixel_write.
REQ-033 When SPRITE_TRANSPARENCY_EN is undefined, 16'hF81F SHALL be written like any other colour.

Structure
REQ-034 Shared package SHALL hold the LCD_WIDTH=240, LCD_HEIGHT=320 and TRANSPARENT_RGB=16'hF81F constants and the FSM state enum.
REQ-035 The pixel address generator (row/col counters and rom_addr calculation) SHALL be the one sub-module, sprite_addr_gen.

Verification
REQ-036 Bench SHALL cover: start with x=95, y=20, id=3, pixel_ready=1 -> 1024 writes over (95..126, 20..51); first rom_addr=3072; done after about 3072 cycles.
REQ-037 Bench SHALL cover: x=230, y=300, id=0 -> only 10x20=200 writes; no pixel_x>239; done still pulses.
REQ-038 Bench SHALL cover: pixel_ready low for 5 cycles on the first write -> pixel_write held, signals stable, no pixel lost; 1024 writes total.
REQ-039 Bench SHALL cover: start re-pulsed mid-draw with id=4 -> ignored; all rom_addr stay in 0..1023 for id=0.
REQ-040 Bench SHALL cover: reset asserted after 100 writes -> next cycle all outputs 0 and busy 0; a new start draws all 1024 pixels.
REQ-041 Bench SHALL cover: SPRITE_TRANSPARENCY_EN defined, ROM with 24 pixels = F81F -> 1000 writes; undefined -> 1024 writes.
